// File: rtl/sumador4bits_display7s.sv
// Registered 4-bit unsigned adder driving three hex 7-segment digits.
// Shows operand X, operand Y and the 4-bit sum; the carry-out has its own line.
// Segment vectors are {g,f,e,d,c,b,a}, active-high, no decimal point.
module sumador4bits_display7s (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] X,
    input  logic [3:0] Y,
    output logic       CarriSalida,
    output logic [6:0] X_Display,
    output logic [6:0] Y_Display,
    output logic [6:0] Resultado_Display
);

    logic [4:0] sum_full;

    // Hex digit to segment pattern; b and d use lower-case glyphs.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

    // Five-bit sum so the carry-out is simply the top bit.
    always_comb begin
        sum_full = {1'b0, X} + {1'b0, Y};
    end

    // Output registers: cleared immediately on reset, loaded every edge otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            CarriSalida       <= 1'b0;
            X_Display         <= 7'h00;
            Y_Display         <= 7'h00;
            Resultado_Display <= 7'h00;
        end else begin
            CarriSalida       <= sum_full[4];
            X_Display         <= hex_to_seg(X);
            Y_Display         <= hex_to_seg(Y);
            Resultado_Display <= hex_to_seg(sum_full[3:0]);
        end
    end

endmodule

// File: tb/tb_sumador4bits_display7s.sv
// Scoreboard bench for sumador4bits_display7s: stimulus pushes expected
// responses, a monitor pops and compares one clock edge later.
`timescale 1ns/1ps
module tb_sumador4bits_display7s;

    logic       clk;
    logic       rst;
    logic [3:0] X;
    logic [3:0] Y;
    logic       CarriSalida;
    logic [6:0] X_Display;
    logic [6:0] Y_Display;
    logic [6:0] Resultado_Display;

    typedef struct {
        int         xv;
        int         yv;
        int         rv;
        logic       c;
        logic [6:0] xd;
        logic [6:0] yd;
        logic [6:0] rd;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    logic [15:0] seen_x = '0;
    logic [15:0] seen_y = '0;
    logic [15:0] seen_r = '0;
    logic [6:0]  glyph [16];
    int   prev_a;
    int   prev_b;

    sumador4bits_display7s dut (
        .clk               (clk),
        .rst               (rst),
        .X                 (X),
        .Y                 (Y),
        .CarriSalida       (CarriSalida),
        .X_Display         (X_Display),
        .Y_Display         (Y_Display),
        .Resultado_Display (Resultado_Display)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        glyph = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    end

    // Reference: plain integer addition, mod 16 digit, glyph lookup.
    function automatic exp_t model(input int a, input int b);
        exp_t e;
        int   s;
        s    = a + b;
        e.xv = a;
        e.yv = b;
        e.rv = s % 16;
        e.c  = (s > 15);
        e.xd = glyph[a];
        e.yd = glyph[b];
        e.rd = glyph[s % 16];
        return e;
    endfunction

    task automatic check_outputs(input string name, input exp_t e, output bit ok);
        tests++;
        ok = (CarriSalida === e.c) && (X_Display === e.xd) &&
             (Y_Display === e.yd) && (Resultado_Display === e.rd);
        if (!ok) begin
            fails++;
            $display("FAIL %s X=%0d Y=%0d got c=%b x=%h y=%h r=%h required c=%b x=%h y=%h r=%h",
                     name, e.xv, e.yv, CarriSalida, X_Display, Y_Display, Resultado_Display,
                     e.c, e.xd, e.yd, e.rd);
        end
    endtask

    task automatic check_reset(input string name);
        exp_t z;
        bit   ok;
        z.xv = prev_a; z.yv = prev_b; z.rv = 0;
        z.c = 1'b0; z.xd = 7'h00; z.yd = 7'h00; z.rd = 7'h00;
        check_outputs(name, z, ok);
    endtask

    // Drive a new operand pair between edges and queue its expected response.
    task automatic drive(input int a, input int b);
        @(negedge clk);
        X = 4'(a);
        Y = 4'(b);
        exp_q.push_back(model(a, b));
        prev_a = a;
        prev_b = b;
    endtask

    // Monitor: the DUT presents a fresh result after every edge with rst low.
    initial begin
        exp_t e;
        bit   ok;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_outputs("scoreboard", e, ok);
                if (ok) begin
                    seen_x[e.xv] = 1'b1;
                    seen_y[e.yv] = 1'b1;
                    seen_r[e.rv] = 1'b1;
                end
            end
        end
    end

    initial begin
        int   pairs[256];
        int   j;
        int   tmp;
        exp_t e;
        bit   ok;

        rst = 1'b1;
        X = 4'd5;
        Y = 4'd6;
        prev_a = 5;
        prev_b = 6;
        #2;
        check_reset("reset_before_clock");
        repeat (2) @(negedge clk);
        check_reset("reset_held");

        // Release mid-cycle; first edge loads 5+6 = b.
        rst = 1'b0;
        exp_q.push_back(model(5, 6));

        drive(3, 4);
        #2;
        check_outputs("hold_before_edge", model(5, 6), ok);
        drive(15, 1);
        drive(15, 15);
        drive(0, 0);

        for (int i = 0; i < 256; i++) pairs[i] = i;
        for (int i = 255; i > 0; i--) begin
            j = int'($urandom_range(i, 0));
            tmp = pairs[i];
            pairs[i] = pairs[j];
            pairs[j] = tmp;
        end

        for (int i = 0; i < 256; i++) begin
            drive(pairs[i] / 16, pairs[i] % 16);
            if (i == 77 || i == 190) begin
                #1 rst = 1'b1;
                #1 check_reset("midrun_reset_assert");
                #1 rst = 1'b0;
                #1 check_reset("midrun_reset_released");
            end
        end

        for (int i = 0; i < 40; i++) begin
            drive(int'($urandom_range(15, 0)), int'($urandom_range(15, 0)));
        end

        repeat (3) @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain pending=%0d required=0", exp_q.size());
        end
        tests++;
        if (seen_x !== 16'hFFFF) begin
            fails++;
            $display("FAIL glyphs_x seen=%h required=ffff", seen_x);
        end
        tests++;
        if (seen_y !== 16'hFFFF) begin
            fails++;
            $display("FAIL glyphs_y seen=%h required=ffff", seen_y);
        end
        tests++;
        if (seen_r !== 16'hFFFF) begin
            fails++;
            $display("FAIL glyphs_r seen=%h required=ffff", seen_r);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
